dep_track_table: RTL and testbench

Multi-lane register dependency table for the instruction buffer. Tracks, per architectural register, which buffer entries read it (RS plane) and write it (RD plane). For each dispatched instruction it returns a registered dependency vector over the buffer entries (RAW, WAR and WAW), including hazards against older lanes of the same dispatch bundle. It also clears an entry's column on retire and maintains a per-entry ready vector for the issue logic.

---
 rtl/dep_pkg.sv | 30 +++
 rtl/dep_lane_lookup.sv | 66 ++++++
 rtl/dep_track_table.sv | 149 ++++++++++++++
 tb/tb_dep_track_table.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dep_pkg.sv
// Shared sizing defaults and lane-slice helpers for the dependency table.
package dep_pkg;

    localparam int DEP_REGNUM = 32;
    localparam int DEP_BS     = 16;
    localparam int RW         = $clog2(DEP_REGNUM);
    localparam int BW         = $clog2(DEP_BS);

    // Widest per-lane field and widest packed lane bus the helpers accept.
    localparam int FIELD_MAX  = 32;
    localparam int BUS_MAX    = 4 * FIELD_MAX;

    function automatic logic [FIELD_MAX-1:0] lane_field(
        input logic [BUS_MAX-1:0] bus,
        input int unsigned        k,
        input int unsigned        w
    );
        logic [BUS_MAX-1:0] shifted;
        shifted = bus >> (k * w);
        return shifted[FIELD_MAX-1:0] & ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic reg_counts(
        input logic [FIELD_MAX-1:0] r,
        input logic                 zero_reg
    );
        return !(zero_reg && (r == '0));
    endfunction

endpackage

// File: rtl/dep_lane_lookup.sv
// Combinational hazard vector for one dispatch lane: table rows plus older-lane matches.
module dep_lane_lookup
    import dep_pkg::*;
#(
    parameter int BS       = DEP_BS,
    parameter int RIDX_W   = RW,
    parameter int BIDX_W   = BW,
    parameter int DW       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [RIDX_W-1:0]    rs1,
    input  logic [RIDX_W-1:0]    rs2,
    input  logic [RIDX_W-1:0]    rd,
    input  logic                 rd_we,
    input  logic [BIDX_W-1:0]    self_index,
    input  logic [BS-1:0]        rd_row_rs1,
    input  logic [BS-1:0]        rd_row_rs2,
    input  logic [BS-1:0]        rs_row_rd,
    input  logic [BS-1:0]        rd_row_rd,
    input  logic [DW-1:0]        older,
    input  logic [DW*RIDX_W-1:0] rs1_all,
    input  logic [DW*RIDX_W-1:0] rs2_all,
    input  logic [DW*RIDX_W-1:0] rd_all,
    input  logic [DW-1:0]        rd_we_all,
    input  logic [DW*BIDX_W-1:0] index_all,
    output logic [BS-1:0]        idt
);

    always_comb begin
        logic              use1;
        logic              use2;
        logic              wr;
        logic              hit;
        logic [RIDX_W-1:0] j_rs1;
        logic [RIDX_W-1:0] j_rs2;
        logic [RIDX_W-1:0] j_rd;
        logic [BIDX_W-1:0] j_idx;

        use1 = reg_counts(32'(rs1), ZERO_REG != 0);
        use2 = reg_counts(32'(rs2), ZERO_REG != 0);
        wr   = rd_we && reg_counts(32'(rd), ZERO_REG != 0);

        idt = '0;
        if (use1) idt = idt | rd_row_rs1;
        if (use2) idt = idt | rd_row_rs2;
        if (wr)   idt = idt | rs_row_rd | rd_row_rd;

        // A match against a counted operand of this lane already excludes register 0.
        for (int j = 0; j < DW; j++) begin
            j_rs1 = RIDX_W'(lane_field(BUS_MAX'(rs1_all), j, RIDX_W));
            j_rs2 = RIDX_W'(lane_field(BUS_MAX'(rs2_all), j, RIDX_W));
            j_rd  = RIDX_W'(lane_field(BUS_MAX'(rd_all), j, RIDX_W));
            j_idx = BIDX_W'(lane_field(BUS_MAX'(index_all), j, BIDX_W));
            hit = 1'b0;
            if (rd_we_all[j])
                hit = (use1 && j_rd == rs1) || (use2 && j_rd == rs2) || (wr && j_rd == rd);
            if (wr)
                hit = hit || (j_rs1 == rd) || (j_rs2 == rd);
            if (older[j] && hit)
                idt[j_idx] = 1'b1;
        end

        idt[self_index] = 1'b0;
    end

endmodule

// File: rtl/dep_track_table.sv
// Register dependency table: RS/RD planes per register, per-entry wait rows and ready vector.
module dep_track_table
    import dep_pkg::*;
#(
    parameter  int REGNUM   = DEP_REGNUM,
    parameter  int BS       = DEP_BS,
    parameter  int DW       = 2,
    parameter  int ZERO_REG = 1,
    localparam int RIDX_W   = $clog2(REGNUM),
    localparam int BIDX_W   = $clog2(BS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        disp_valid,
    input  logic [DW*RIDX_W-1:0] rs1,
    input  logic [DW*RIDX_W-1:0] rs2,
    input  logic [DW*RIDX_W-1:0] rd,
    input  logic [DW-1:0]        rd_we,
    input  logic [DW*BIDX_W-1:0] buffer_index,
    input  logic                 ret_valid,
    input  logic [BIDX_W-1:0]    ret_index,
    output logic [DW-1:0]        idt_valid,
    output logic [DW*BS-1:0]     idt,
    output logic [BS-1:0]        ready
);

    logic [BS-1:0] rs_tab   [REGNUM];
    logic [BS-1:0] rd_tab   [REGNUM];
    logic [BS-1:0] dep_wait [BS];
    logic [BS-1:0] live;

    logic [BS-1:0] rs_ret   [REGNUM];
    logic [BS-1:0] rd_ret   [REGNUM];
    logic [BS-1:0] wait_ret [BS];
    logic [BS-1:0] live_ret;

    logic [BS-1:0] rs_nxt   [REGNUM];
    logic [BS-1:0] rd_nxt   [REGNUM];
    logic [BS-1:0] wait_nxt [BS];
    logic [BS-1:0] live_nxt;

    logic [RIDX_W-1:0] lane_rs1    [DW];
    logic [RIDX_W-1:0] lane_rs2    [DW];
    logic [RIDX_W-1:0] lane_rd     [DW];
    logic [BIDX_W-1:0] lane_idx    [DW];
    logic [DW-1:0]     older_lanes [DW];
    logic [BS-1:0]     lane_idt    [DW];

    // Retire happens first so a same-cycle lookup never sees the retiring producer.
    always_comb begin
        rs_ret   = rs_tab;
        rd_ret   = rd_tab;
        wait_ret = dep_wait;
        live_ret = live;
        if (ret_valid) begin
            for (int r = 0; r < REGNUM; r++) begin
                rs_ret[r][ret_index] = 1'b0;
                rd_ret[r][ret_index] = 1'b0;
            end
            for (int e = 0; e < BS; e++)
                wait_ret[e][ret_index] = 1'b0;
            live_ret[ret_index] = 1'b0;
        end
    end

    for (genvar k = 0; k < DW; k++) begin : g_lane
        assign lane_rs1[k]    = RIDX_W'(lane_field(BUS_MAX'(rs1), k, RIDX_W));
        assign lane_rs2[k]    = RIDX_W'(lane_field(BUS_MAX'(rs2), k, RIDX_W));
        assign lane_rd[k]     = RIDX_W'(lane_field(BUS_MAX'(rd), k, RIDX_W));
        assign lane_idx[k]    = BIDX_W'(lane_field(BUS_MAX'(buffer_index), k, BIDX_W));
        assign older_lanes[k] = disp_valid & DW'((32'd1 << k) - 32'd1);

        dep_lane_lookup #(
            .BS       (BS),
            .RIDX_W   (RIDX_W),
            .BIDX_W   (BIDX_W),
            .DW       (DW),
            .ZERO_REG (ZERO_REG)
        ) u_lookup (
            .rs1        (lane_rs1[k]),
            .rs2        (lane_rs2[k]),
            .rd         (lane_rd[k]),
            .rd_we      (rd_we[k]),
            .self_index (lane_idx[k]),
            .rd_row_rs1 (rd_ret[lane_rs1[k]]),
            .rd_row_rs2 (rd_ret[lane_rs2[k]]),
            .rs_row_rd  (rs_ret[lane_rd[k]]),
            .rd_row_rd  (rd_ret[lane_rd[k]]),
            .older      (older_lanes[k]),
            .rs1_all    (rs1),
            .rs2_all    (rs2),
            .rd_all     (rd),
            .rd_we_all  (rd_we),
            .index_all  (buffer_index),
            .idt        (lane_idt[k])
        );
    end

    // Insert in ascending lane order; a later lane reusing an index overwrites the column.
    always_comb begin
        rs_nxt   = rs_ret;
        rd_nxt   = rd_ret;
        wait_nxt = wait_ret;
        live_nxt = live_ret;
        for (int k = 0; k < DW; k++) begin
            if (disp_valid[k]) begin
                for (int r = 0; r < REGNUM; r++) begin
                    rs_nxt[r][lane_idx[k]] = 1'b0;
                    rd_nxt[r][lane_idx[k]] = 1'b0;
                end
                if (reg_counts(32'(lane_rs1[k]), ZERO_REG != 0))
                    rs_nxt[lane_rs1[k]][lane_idx[k]] = 1'b1;
                if (reg_counts(32'(lane_rs2[k]), ZERO_REG != 0))
                    rs_nxt[lane_rs2[k]][lane_idx[k]] = 1'b1;
                if (rd_we[k] && reg_counts(32'(lane_rd[k]), ZERO_REG != 0))
                    rd_nxt[lane_rd[k]][lane_idx[k]] = 1'b1;
                wait_nxt[lane_idx[k]] = lane_idt[k];
                live_nxt[lane_idx[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REGNUM; r++) begin
                rs_tab[r] <= '1;
                rd_tab[r] <= '1;
            end
            for (int e = 0; e < BS; e++)
                dep_wait[e] <= '0;
            live      <= '0;
            idt_valid <= '0;
            idt       <= '0;
            ready     <= '0;
        end else begin
            rs_tab    <= rs_nxt;
            rd_tab    <= rd_nxt;
            dep_wait  <= wait_nxt;
            live      <= live_nxt;
            idt_valid <= disp_valid;
            for (int k = 0; k < DW; k++)
                if (disp_valid[k])
                    idt[k*BS +: BS] <= lane_idt[k];
            for (int e = 0; e < BS; e++)
                ready[e] <= live_nxt[e] & ~|wait_nxt[e];
        end
    end

endmodule

// File: tb/tb_dep_track_table.sv
// Bench for dep_track_table (DW=2, ZERO_REG=1): directed scenarios plus random traffic vs an entry-centric model.
module tb_dep_track_table;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  disp_valid;
    logic [9:0]  rs1, rs2, rd;
    logic [1:0]  rd_we;
    logic [7:0]  buffer_index;
    logic        ret_valid;
    logic [3:0]  ret_index;
    logic [1:0]  idt_valid;
    logic [31:0] idt;
    logic [15:0] ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dep_track_table #(.REGNUM(32), .BS(16), .DW(2), .ZERO_REG(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .rd_we        (rd_we),
        .buffer_index (buffer_index),
        .ret_valid    (ret_valid),
        .ret_index    (ret_index),
        .idt_valid    (idt_valid),
        .idt          (idt),
        .ready        (ready)
    );

    // Two lanes sharing a buffer entry in one bundle is illegal stimulus.
    always @(posedge clk)
        if (rst === 1'b0 && disp_valid === 2'b11)
            assert (buffer_index[3:0] != buffer_index[7:4])
            else $error("duplicate buffer_index %0d in one bundle", buffer_index[3:0]);

    // Lane stimulus
    logic       l_v   [2];
    logic [4:0] l_rs1 [2];
    logic [4:0] l_rs2 [2];
    logic [4:0] l_rd  [2];
    logic       l_we  [2];
    logic [3:0] l_idx [2];

    // Model: per entry, the set of registers it reads and writes.
    logic [31:0] m_reads  [16];
    logic [31:0] m_writes [16];
    logic [15:0] m_wait   [16];
    logic [15:0] m_live;
    logic [15:0] m_ready;
    logic [15:0] m_idt    [2];
    logic [1:0]  m_vld;

    function automatic bit op(input logic [4:0] r);
        return r != 5'd0;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < 16; e++) begin
            m_reads[e]  = '1;
            m_writes[e] = '1;
            m_wait[e]   = '0;
        end
        m_live  = '0;
        m_ready = '0;
        m_idt[0] = '0;
        m_idt[1] = '0;
        m_vld   = '0;
    endtask

    task automatic model_step();
        logic [15:0] dep [2];
        if (ret_valid) begin
            m_reads[ret_index]  = '0;
            m_writes[ret_index] = '0;
            m_live[ret_index]   = 1'b0;
            for (int e = 0; e < 16; e++) m_wait[e][ret_index] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            dep[k] = '0;
            if (l_v[k]) begin
                for (int e = 0; e < 16; e++) begin
                    if (op(l_rs1[k]) && m_writes[e][l_rs1[k]]) dep[k][e] = 1'b1;
                    if (op(l_rs2[k]) && m_writes[e][l_rs2[k]]) dep[k][e] = 1'b1;
                    if (l_we[k] && op(l_rd[k]) && (m_reads[e][l_rd[k]] || m_writes[e][l_rd[k]]))
                        dep[k][e] = 1'b1;
                end
                for (int j = 0; j < k; j++) begin
                    if (l_v[j]) begin
                        if (l_we[j] && op(l_rd[j]) &&
                            ((op(l_rs1[k]) && l_rd[j] == l_rs1[k]) ||
                             (op(l_rs2[k]) && l_rd[j] == l_rs2[k]) ||
                             (l_we[k] && op(l_rd[k]) && l_rd[j] == l_rd[k])))
                            dep[k][l_idx[j]] = 1'b1;
                        if (l_we[k] && op(l_rd[k]) && (l_rs1[j] == l_rd[k] || l_rs2[j] == l_rd[k]))
                            dep[k][l_idx[j]] = 1'b1;
                    end
                end
                dep[k][l_idx[k]] = 1'b0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (l_v[k]) begin
                m_reads[l_idx[k]]  = '0;
                m_writes[l_idx[k]] = '0;
                if (op(l_rs1[k])) m_reads[l_idx[k]][l_rs1[k]] = 1'b1;
                if (op(l_rs2[k])) m_reads[l_idx[k]][l_rs2[k]] = 1'b1;
                if (l_we[k] && op(l_rd[k])) m_writes[l_idx[k]][l_rd[k]] = 1'b1;
                m_wait[l_idx[k]] = dep[k];
                m_live[l_idx[k]] = 1'b1;
                m_idt[k] = dep[k];
            end
        end
        m_vld = {l_v[1], l_v[0]};
        for (int e = 0; e < 16; e++) m_ready[e] = m_live[e] && (m_wait[e] == 16'd0);
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            l_v[k] = 1'b0; l_rs1[k] = '0; l_rs2[k] = '0; l_rd[k] = '0; l_we[k] = 1'b0; l_idx[k] = '0;
        end
        ret_valid = 1'b0;
        ret_index = '0;
    endtask

    task automatic set_lane(input int k, input int a, input int b, input int d, input int we, input int idx);
        l_v[k]   = 1'b1;
        l_rs1[k] = 5'(a);
        l_rs2[k] = 5'(b);
        l_rd[k]  = 5'(d);
        l_we[k]  = (we != 0);
        l_idx[k] = 4'(idx);
    endtask

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            disp_valid[k]         = l_v[k];
            rs1[k*5 +: 5]         = l_rs1[k];
            rs2[k*5 +: 5]         = l_rs2[k];
            rd[k*5 +: 5]          = l_rd[k];
            rd_we[k]              = l_we[k];
            buffer_index[k*4 +: 4] = l_idx[k];
        end
    endtask

    task automatic cycle();
        drive();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        drive();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (idt_valid !== 2'b00) begin failures++; $display("FAIL reset_idt_valid got=%b want=00", idt_valid); end
        checks++; if (idt !== 32'd0) begin failures++; $display("FAIL reset_idt got=%h want=0", idt); end
        checks++; if (ready !== 16'd0) begin failures++; $display("FAIL reset_ready got=%h want=0", ready); end
        rst = 1'b0;
    endtask

    task automatic test_first_dispatch();
        idle(); set_lane(0, 1, 2, 3, 1, 0); cycle();
        checks++; if (idt[15:0] !== 16'hFFFE) begin failures++; $display("FAIL first_idt0 got=%h want=fffe", idt[15:0]); end
        checks++; if (idt_valid !== 2'b01) begin failures++; $display("FAIL first_vld got=%b want=01", idt_valid); end
        idle(); cycle();
        checks++; if (idt_valid !== 2'b00) begin failures++; $display("FAIL idle_vld got=%b want=00", idt_valid); end
        checks++; if (idt[15:0] !== 16'hFFFE) begin failures++; $display("FAIL idt_hold got=%h want=fffe", idt[15:0]); end
    endtask

    task automatic test_retire_chain();
        for (int e = 1; e < 16; e++) begin
            idle(); ret_valid = 1'b1; ret_index = 4'(e); cycle();
        end
        checks++; if (ready !== m_ready || ready[0] !== 1'b1) begin failures++; $display("FAIL chain_ready0 got=%h want=%h", ready, m_ready); end
        idle(); set_lane(0, 0, 0, 5, 1, 2); cycle();
        checks++; if (idt[15:0] !== 16'h0000) begin failures++; $display("FAIL producer_idt got=%h want=0000", idt[15:0]); end
        idle(); set_lane(0, 5, 0, 0, 0, 4); cycle();
        checks++; if (idt[15:0] !== 16'h0004) begin failures++; $display("FAIL raw_idt got=%h want=0004", idt[15:0]); end
        checks++; if (ready[4] !== 1'b0) begin failures++; $display("FAIL ready4_blocked got=%b want=0", ready[4]); end
        idle(); ret_valid = 1'b1; ret_index = 4'd2; cycle();
        checks++; if (ready[4] !== 1'b1) begin failures++; $display("FAIL ready4_after_retire got=%b want=1", ready[4]); end
        checks++; if (ready !== m_ready) begin failures++; $display("FAIL chain_ready got=%h want=%h", ready, m_ready); end
    endtask

    task automatic test_same_bundle();
        idle(); set_lane(0, 0, 0, 7, 1, 3); set_lane(1, 0, 7, 0, 0, 6); cycle();
        checks++; if (idt[16+3] !== 1'b1 || idt[31:16] !== m_idt[1]) begin failures++; $display("FAIL bundle_idt1 got=%h want=%h", idt[31:16], m_idt[1]); end
        checks++; if (idt[6] !== 1'b0 || idt[15:0] !== m_idt[0]) begin failures++; $display("FAIL bundle_idt0 got=%h want=%h", idt[15:0], m_idt[0]); end
        checks++; if (idt_valid !== 2'b11) begin failures++; $display("FAIL bundle_vld got=%b want=11", idt_valid); end
    endtask

    task automatic test_zero_reg();
        idle(); set_lane(0, 0, 0, 0, 1, 1); cycle();
        checks++; if (idt[15:0] !== 16'h0000) begin failures++; $display("FAIL zero_write_idt got=%h want=0000", idt[15:0]); end
        idle(); set_lane(0, 0, 0, 0, 1, 8); cycle();
        checks++; if (idt[15:0] !== 16'h0000) begin failures++; $display("FAIL zero_read_idt got=%h want=0000", idt[15:0]); end
    endtask

    task automatic test_retire_dispatch_same();
        idle(); set_lane(0, 9, 0, 10, 1, 5); cycle();
        idle(); ret_valid = 1'b1; ret_index = 4'd5; set_lane(0, 11, 12, 13, 1, 5); cycle();
        checks++; if (ready[5] !== 1'b1 || ready !== m_ready) begin failures++; $display("FAIL same_idx_ready got=%h want=%h", ready, m_ready); end
        idle(); set_lane(0, 0, 0, 9, 1, 7); cycle();
        checks++; if (idt[5] !== 1'b0 || idt[15:0] !== m_idt[0]) begin failures++; $display("FAIL old_column_gone got=%h want=%h", idt[15:0], m_idt[0]); end
        idle(); set_lane(0, 0, 0, 11, 1, 9); cycle();
        checks++; if (idt[5] !== 1'b1 || idt[15:0] !== m_idt[0]) begin failures++; $display("FAIL new_column_war got=%h want=%h", idt[15:0], m_idt[0]); end
    endtask

    task automatic test_reset_mid_bundle();
        idle(); set_lane(0, 3, 4, 5, 1, 10); set_lane(1, 5, 6, 7, 1, 11); drive();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (idt_valid !== 2'b00) begin failures++; $display("FAIL async_reset_vld got=%b want=00", idt_valid); end
        @(posedge clk);
        #1;
        checks++; if (idt_valid !== 2'b00 || ready !== 16'd0) begin failures++; $display("FAIL reset_hold vld=%b ready=%h want=00/0000", idt_valid, ready); end
        idle(); drive();
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (idt_valid !== 2'b00) begin failures++; $display("FAIL post_reset_vld got=%b want=00", idt_valid); end
        idle(); set_lane(0, 1, 2, 3, 1, 0); cycle();
        checks++; if (idt[15:0] !== 16'hFFFE || idt_valid !== 2'b01) begin failures++; $display("FAIL post_reset_idt got=%h/%b want=fffe/01", idt[15:0], idt_valid); end
    endtask

    task automatic test_back_to_back_random();
        int i0;
        for (int n = 0; n < 600; n++) begin
            idle();
            i0 = int'($urandom_range(15, 0));
            if ($urandom_range(3, 0) != 0)
                set_lane(0, $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(1, 0), i0);
            if ($urandom_range(3, 0) != 0)
                set_lane(1, $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(1, 0),
                         (i0 + int'($urandom_range(15, 1))) % 16);
            if ($urandom_range(1, 0) != 0) begin
                ret_valid = 1'b1;
                ret_index = 4'($urandom_range(15, 0));
            end
            cycle();
            checks++; if (idt_valid !== m_vld) begin failures++; $display("FAIL rand_vld n=%0d got=%b want=%b", n, idt_valid, m_vld); end
            checks++; if (idt[15:0] !== m_idt[0]) begin failures++; $display("FAIL rand_idt0 n=%0d got=%h want=%h", n, idt[15:0], m_idt[0]); end
            checks++; if (idt[31:16] !== m_idt[1]) begin failures++; $display("FAIL rand_idt1 n=%0d got=%h want=%h", n, idt[31:16], m_idt[1]); end
            checks++; if (ready !== m_ready) begin failures++; $display("FAIL rand_ready n=%0d got=%h want=%h", n, ready, m_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_first_dispatch();
        test_retire_chain();
        test_same_bundle();
        test_zero_reg();
        test_retire_dispatch_same();
        test_reset_mid_bundle();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
